// File: rtl/cov_pkg.sv
// cov_pkg: shared widths, upper-triangle tables and FSM encoding for cov_fetch.
package cov_pkg;
    localparam int DW = 16;
    localparam int NBINS = 129;
    localparam int NELEM = 4;
    localparam int NUPPER = NELEM * (NELEM + 1) / 2;
    // Store element fetched for each upper-triangle slot, slot 0 rightmost
    localparam logic [NUPPER-1:0][3:0] UT_ELEM = {
        4'd15, 4'd11, 4'd10, 4'd7, 4'd6, 4'd5, 4'd3, 4'd2, 4'd1, 4'd0
    };
    // Upper slot holding each row-major element; lower elements map to their mirror
    localparam logic [15:0][3:0] SLOT_MAP = {
        4'd9, 4'd8, 4'd6, 4'd3,
        4'd8, 4'd7, 4'd5, 4'd2,
        4'd6, 4'd5, 4'd4, 4'd1,
        4'd3, 4'd2, 4'd1, 4'd0
    };
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, STREAM} state_t;
endpackage

// File: rtl/cov_fetch_if.sv
// cov_fetch_if: request, store-read and matrix-stream signals of cov_fetch.
interface cov_fetch_if #(parameter int DW = cov_pkg::DW);
    logic                 req_valid;
    logic [7:0]           req_bin;
    logic                 req_ready;
    logic                 req_err;
    logic                 rd_en;
    logic [7:0]           rd_bin;
    logic [3:0]           rd_elem;
    logic signed [DW-1:0] rd_re;
    logic signed [DW-1:0] rd_im;
    logic                 rd_valid;
    logic                 m_valid;
    logic                 m_ready;
    logic signed [DW-1:0] m_re;
    logic signed [DW-1:0] m_im;
    logic [3:0]           m_elem;
    logic                 m_last;
    logic                 busy;
    modport master (
        output req_valid, req_bin, rd_re, rd_im, rd_valid, m_ready,
        input  req_ready, req_err, rd_en, rd_bin, rd_elem, m_valid, m_re, m_im, m_elem, m_last, busy
    );
    modport slave (
        input  req_valid, req_bin, rd_re, rd_im, rd_valid, m_ready,
        output req_ready, req_err, rd_en, rd_bin, rd_elem, m_valid, m_re, m_im, m_elem, m_last, busy
    );
endinterface

// File: rtl/cov_conj_sat.sv
// cov_conj_sat: complex conjugate; the negated imaginary part saturates at the positive limit.
module cov_conj_sat #(parameter int DW = 16) (
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im
);
    localparam logic signed [DW-1:0] MIN = {1'b1, {(DW-1){1'b0}}};
    always_comb begin
        out_re = in_re;
        out_im = in_im == MIN ? ~MIN : -in_im;
    end
endmodule

// File: rtl/cov_fetch.sv
// cov_fetch: fetches the upper triangle of a 4x4 Hermitian covariance bin and streams the full matrix.
module cov_fetch
    import cov_pkg::*;
#(
    parameter int DW = cov_pkg::DW,
    parameter int NBINS = cov_pkg::NBINS
) (
    input logic clk,
    input logic rst_n,
    cov_fetch_if.slave bus
);
    localparam logic [8:0] NB = 9'(NBINS);
    localparam logic [3:0] NUP = 4'(NUPPER);
    state_t state;
    logic [3:0] iss_cnt, cap_cnt, nxt, slot;
    logic signed [DW-1:0] mat_re [NUPPER];
    logic signed [DW-1:0] mat_im [NUPPER];
    logic signed [DW-1:0] cj_re, cj_im, nxt_re, nxt_im;
    logic accept, reject, capture, cap_last, lower;
    always_comb begin
        accept   = state == IDLE && bus.req_valid && bus.req_ready && {1'b0, bus.req_bin} < NB;
        reject   = state == IDLE && bus.req_valid && bus.req_ready && {1'b0, bus.req_bin} >= NB;
        capture  = (state == FETCH || state == DRAIN) && bus.rd_valid && cap_cnt < NUP;
        cap_last = capture && cap_cnt == NUP - 4'd1;
        nxt      = state == STREAM ? bus.m_elem + 4'd1 : 4'd0;
        slot     = SLOT_MAP[nxt];
        lower    = nxt[3:2] > nxt[1:0];
        nxt_re   = cj_re;
        nxt_im   = lower ? cj_im : mat_im[slot];
    end
    cov_conj_sat #(.DW(DW)) u_conj (
        .in_re (mat_re[slot]),
        .in_im (mat_im[slot]),
        .out_re(cj_re),
        .out_im(cj_im)
    );
    // Matrix storage is left uncleared by reset; capture is gated by state instead
    always_ff @(posedge clk) begin
        if (capture) begin
            mat_re[cap_cnt] <= bus.rd_re;
            mat_im[cap_cnt] <= bus.rd_im;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            iss_cnt       <= '0;
            cap_cnt       <= '0;
            bus.req_ready <= 1'b0;
            bus.req_err   <= 1'b0;
            bus.rd_en     <= 1'b0;
            bus.rd_bin    <= '0;
            bus.rd_elem   <= '0;
            bus.m_valid   <= 1'b0;
            bus.m_re      <= '0;
            bus.m_im      <= '0;
            bus.m_elem    <= '0;
            bus.m_last    <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.req_err <= 1'b0;
            if (capture) cap_cnt <= cap_cnt + 4'd1;
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    bus.req_err   <= reject;
                    if (accept) begin
                        state         <= FETCH;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        bus.rd_en     <= 1'b1;
                        bus.rd_bin    <= bus.req_bin;
                        bus.rd_elem   <= UT_ELEM[0];
                        iss_cnt       <= 4'd1;
                        cap_cnt       <= '0;
                    end
                end
                FETCH: begin
                    if (iss_cnt == NUP) begin
                        bus.rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        bus.rd_elem <= UT_ELEM[iss_cnt];
                        iss_cnt     <= iss_cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (cap_last) begin
                        state       <= STREAM;
                        bus.m_valid <= 1'b1;
                        bus.m_elem  <= nxt;
                        bus.m_re    <= nxt_re;
                        bus.m_im    <= nxt_im;
                        bus.m_last  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (bus.m_valid && bus.m_ready) begin
                        if (bus.m_last) begin
                            state         <= IDLE;
                            bus.m_valid   <= 1'b0;
                            bus.m_last    <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.req_ready <= 1'b1;
                        end else begin
                            bus.m_elem <= nxt;
                            bus.m_re   <= nxt_re;
                            bus.m_im   <= nxt_im;
                            bus.m_last <= nxt == 4'd15;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/cov_fetch.md
COV_FETCH -- requirements
Module: cov_fetch

Interface
REQ-001 SHALL have parameters: DW, default 16, sample width (Q1.15); NBINS, default 129, number of frequency bins.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: req_valid  in  1, req_bin  in  8, req_ready  out  1  matrix-fetch request handshake.
REQ-005 SHALL have ports: req_err  out  1  one-cycle pulse, request rejected.
REQ-006 SHALL have ports: rd_en  out  1, rd_bin  out  8, rd_elem  out  4  covariance store read command.
REQ-007 SHALL have ports: rd_re, rd_im  in  DW (signed), rd_valid  in  1  covariance store read return.
REQ-008 SHALL have ports: m_valid  out  1, m_ready  in  1, m_re, m_im  out  DW (signed), m_elem  out  4, m_last  out  1  matrix output stream.
REQ-009 SHALL have ports: busy  out  1  high in any state other than IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, DRAIN, STREAM.
REQ-011 IDLE: req_ready=1; a handshake (req_valid&&req_ready) with req_bin<NBINS latches bin and moves to FETCH.
REQ-012 Handshake with req_bin>=NBINS SHALL pulse req_err for one cycle, issue no reads and remain in IDLE.
REQ-013 FETCH SHALL assert rd_en on 10 consecutive cycles, rd_bin = latched bin, rd_elem in order 0,1,2,3,5,6,7,10,11,15 (upper triangle, elem=row*4+col); then DRAIN.
REQ-014 Store latency is 1 cycle: rd_valid/rd_re/rd_im are valid the cycle after rd_en; capture counter independent of issue counter; the nth rd_valid fills the nth upper-triangle slot.
REQ-015 DRAIN SHALL wait for the 10th capture, then enter STREAM; rd_valid in IDLE or STREAM SHALL be ignored.
REQ-016 Request accepted at edge T: rd_en high in cycles T+1..T+10, first m_valid in cycle T+12.
REQ-017 STREAM SHALL emit 16 beats, m_elem 0..15 row-major; m_last=1 only on m_elem=15.
REQ-018 Beats with row<=col SHALL carry the captured value unchanged (diagonal imag passed as read).
REQ-019 Beats with row>col SHALL carry conj of captured (col,row): re unchanged, im negated, saturating -(-32768)=32767.
REQ-020 m_valid, m_re, m_im, m_elem, m_last SHALL be registered and held stable while m_valid&&!m_ready.
REQ-021 Beat advances only on m_valid&&m_ready; with m_ready constantly 1, 16 beats in 16 consecutive cycles.
REQ-022 After the m_last handshake, FSM SHALL return to IDLE; req_ready=1 the following cycle; m_valid=0 that cycle.
REQ-023 req_ready SHALL be 0 in FETCH, DRAIN, STREAM; requests there are not accepted.

Reset
REQ-024 While rst_n=0 at a rising edge: state=IDLE; req_ready, req_err, rd_en, m_valid, m_last, busy=0; rd_bin, rd_elem, m_re, m_im, m_elem=0; counters=0.
REQ-025 req_ready SHALL rise the first cycle after rst_n returns high.
REQ-026 Reset mid-FETCH/DRAIN/STREAM SHALL abort the transfer; late rd_valid after reset SHALL be ignored; local matrix registers need not be cleared.

Structure
REQ-027 Shared package cov_pkg SHALL hold DW, NBINS, NELEM=4, the 10-entry upper-triangle elem table, the upper-slot index map per (row,col), and the FSM state encoding.
REQ-028 Saturating conjugate SHALL be a sub-module cov_conj_sat (DW in re/im, out re/-im saturated), combinational, one instance on the output path.

Verification
REQ-029 Store bin 0 R00=(2048,0); request bin 0, m_ready=1 -> beat elem 0 = (2048,0), 16 beats, m_last on elem 15 only, first m_valid 12 cycles after accept.
REQ-030 Store bin 1 R01=(0,-2048); request bin 1 -> elem 1 = (0,-2048), elem 4 = (0,2048).
REQ-031 Store R02 im=-32768 -> elem 8 im=32767, elem 2 im=-32768.
REQ-032 Drop m_ready for 3 cycles at elem 5 -> m_valid, m_elem=5, data held stable; stream resumes at elem 6, no beat lost or duplicated.
REQ-033 Request bin 129 -> req_err one cycle, zero rd_en cycles, req_ready stays 1.
REQ-034 rst_n=0 one cycle during 6th rd_en of FETCH -> rd_en=0, m_valid=0 next cycle; new request bin 0 after reset completes normally per REQ-029.
